// File: rtl/seq_bitwise_pkg.sv
// Shared definitions for the sequential bitwise unit: op codes, FSM state
// encoding and the slice-counter width helper.
package seq_bitwise_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PAR  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_bitwise_unit_slice_logic.sv
// Combinational per-slice operator for seq_bitwise_unit. Produces the
// SLICE-bit result for one op and the XOR-reduction of that result.
module slice_logic
  import seq_bitwise_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y,
  output logic             par
);

  // Operator select; PAR passes operand A through so its parity can be folded.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_PAR:  y = a;
      default: y = '0;
    endcase
    par = ^y;
  end

endmodule

// File: rtl/seq_bitwise_unit.sv
// Multi-cycle bitwise logic unit: processes a WIDTH-bit operand pair SLICE
// bits per cycle (LSB slice first) behind valid/ready handshakes.
// Optional feature: define SEQ_BITWISE_UNIT_ZERO_EN to add the `zero` output
// (1 iff the WIDTH-bit result is all zeros).
module seq_bitwise_unit
  import seq_bitwise_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
`ifdef SEQ_BITWISE_UNIT_ZERO_EN
  ,
  output logic             zero
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic             par_q;
  logic [SLICE-1:0] slice_y;
  logic             slice_par;
  logic             last;
  logic             accept;

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & (state == ST_IDLE);
  assign last     = (k == KW'(N - 1));
  assign out      = {par_q, res_q};

  // The current slice is always the bottom SLICE bits of the shifted operands.
  slice_logic #(.SLICE(SLICE)) u_slice (
    .op  (op_q),
    .a   (a_sh[SLICE-1:0]),
    .b   (b_sh[SLICE-1:0]),
    .y   (slice_y),
    .par (slice_par)
  );

  // FSM, slice counter, result register and parity flag accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      k         <= '0;
      res_q     <= '0;
      par_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            k     <= '0;
            res_q <= '0;
            par_q <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[int'(k)*SLICE +: SLICE] <= slice_y;
          if (op_q == OP_PAR) par_q <= par_q ^ slice_par;
          k <= k + 1'b1;
          if (last) begin
            k         <= '0;
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch on accept, then shift one slice per RUN cycle; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      a_sh <= in_a;
      b_sh <= in_b;
    end else if (state == ST_RUN) begin
      a_sh <= a_sh >> SLICE;
      b_sh <= b_sh >> SLICE;
    end
  end

`ifdef SEQ_BITWISE_UNIT_ZERO_EN
  logic zero_q;
  assign zero = zero_q;

  // Zero flag starts true on accept and is cleared by any nonzero slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b1;
    end else if (state == ST_RUN) begin
      zero_q <= zero_q & ~(|slice_y);
    end
  end
`endif

endmodule

// File: tb/tb_seq_bitwise_unit.sv
// Directed testbench for seq_bitwise_unit (WIDTH=8, SLICE=2).
module tb_seq_bitwise_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out;
`ifdef SEQ_BITWISE_UNIT_ZERO_EN
  logic       zero;
`endif

  int checks;
  int errors;

  seq_bitwise_unit #(.WIDTH(8), .SLICE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SEQ_BITWISE_UNIT_ZERO_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request from IDLE, wait (bounded) for out_valid, capture the
  // result and complete the handshake with out_ready high.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [8:0] res, output int edges);
    op = o; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    res = out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'd0; in_a = 8'hFF; in_b = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
    checks++; if (out !== 9'h000) begin errors++; $display("FAIL rst_out got %h expected 000", out); end
`ifdef SEQ_BITWISE_UNIT_ZERO_EN
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b expected 0", zero); end
`endif
    in_valid = 1'b0;
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    int edges;
    op = 3'd0; in_a = 8'hF0; in_b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_run_in_ready got %b expected 0 at edge %0d", in_ready, edges); end
      @(posedge clk); #1;
      edges++;
    end
    checks++; if (edges !== 5) begin errors++; $display("FAIL and_latency got %0d expected 5", edges); end
    checks++; if (out !== 9'h030) begin errors++; $display("FAIL and_out got %h expected 030", out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_done_in_ready got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_after_hs_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL and_after_hs_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_logic_ops();
    logic [2:0] ops [6] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd1, 3'd6};
    logic [7:0] va  [6] = '{8'hA5, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'hF0};
    logic [7:0] vb  [6] = '{8'hFF, 8'h3C, 8'h3C, 8'h3C, 8'h30, 8'h3C};
    logic [8:0] exp [6] = '{9'h05A, 9'h0CF, 9'h003, 9'h0CC, 9'h03F, 9'h033};
    logic [8:0] res;
    int edges;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], res, edges);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL op%0d_out got %h expected %h", ops[i], res, exp[i]); end
      checks++; if (edges !== 5) begin errors++; $display("FAIL op%0d_latency got %0d expected 5", ops[i], edges); end
    end
  endtask

  task automatic test_par();
    logic [7:0] va  [4] = '{8'h07, 8'h03, 8'hFF, 8'h80};
    logic [8:0] exp [4] = '{9'h107, 9'h003, 9'h0FF, 9'h180};
    logic [8:0] res;
    int edges;
    for (int i = 0; i < 4; i++) begin
      run_op(3'd7, va[i], 8'h55, res, edges);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL par_%h_out got %h expected %h", va[i], res, exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    int edges;
    op = 3'd6; in_a = 8'h0F; in_b = 8'h0F; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++; if (out !== 9'h0FF) begin errors++; $display("FAIL bp_out got %h expected 0FF", out); end
    op = 3'd0; in_a = 8'hFF; in_b = 8'h0F; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b expected 1 cycle %0d", out_valid, c); end
      checks++; if (out !== 9'h0FF) begin errors++; $display("FAIL bp_hold_out got %h expected 0FF cycle %0d", out, c); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b expected 0 cycle %0d", in_ready, c); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_hs_in_ready got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b expected 0", in_ready); end
    edges = 1;
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++; if (edges !== 5) begin errors++; $display("FAIL bp_second_latency got %0d expected 5", edges); end
    checks++; if (out !== 9'h00F) begin errors++; $display("FAIL bp_second_out got %h expected 00F", out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    op = 3'd1; in_a = 8'h0F; in_b = 8'h30; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b expected 0", out_valid); end
    checks++; if (out !== 9'h000) begin errors++; $display("FAIL mid_rst_out got %h expected 000", out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b expected 0", in_ready); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_release_in_ready got %b expected 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_pulse got %b expected 0 cycle %0d", out_valid, c); end
    end
  endtask

`ifdef SEQ_BITWISE_UNIT_ZERO_EN
  task automatic test_zero();
    int edges;
    op = 3'd2; in_a = 8'h5A; in_b = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin @(posedge clk); #1; edges++; end
    checks++; if (out !== 9'h000) begin errors++; $display("FAIL zero_xor_out got %h expected 000", out); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zero_xor_flag got %b expected 1", zero); end
    @(posedge clk); #1;
    op = 3'd2; in_a = 8'h01; in_b = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 30) begin @(posedge clk); #1; edges++; end
    checks++; if (out !== 9'h001) begin errors++; $display("FAIL nz_xor_out got %h expected 001", out); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL nz_xor_flag got %b expected 0", zero); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    test_reset();
    test_and();
    test_logic_ops();
    test_par();
    test_backpressure();
    test_reset_mid();
`ifdef SEQ_BITWISE_UNIT_ZERO_EN
    test_zero();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
